mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_pkg.sv | 26 ++
 rtl/bus_timeout_ctr.sv | 25 ++
 rtl/mem_port_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_port_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory-port controller and its timeout counter.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } kind_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TMO_W           = 8;

  // WRITE outranks LOAD, LOAD outranks FETCH.
  function automatic kind_t decode_kind(input logic mem_write, input logic adr_src);
    if (mem_write) return WRITE;
    if (adr_src)   return LOAD;
    return FETCH;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// 8-bit bus wait counter; expired flags the wait cycle in which the count reaches LIMIT.
module bus_timeout_ctr
  import mem_port_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + TMO_W'(1);
  end

  // The abort edge is the same edge on which the count becomes LIMIT.
  assign expired = enable && (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Multi-cycle memory port: arbitrates fetch/load/store onto a req/ack bus and holds the CPU via stall.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ir_write,
  input  logic            adr_src,
  input  logic            mem_write,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] wdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] data,
  output logic            stall,
  output logic            err
);

  state_t          state, state_nxt;
  kind_t           kind_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] addr_c;
  logic            req_c;
  logic            accept_c, misalign_c, complete_c, timeout_c;
  logic            tmo_expired;

  assign req_c   = ir_write | mem_write | adr_src;
  assign addr_c  = (adr_src | mem_write) ? alu_out : pc;
  assign stall   = req_c & (state != DONE);
  assign bus_req = (state == BUSY);

  bus_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept_c),
    .enable (bus_req & ~bus_ack),
    .expired(tmo_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    misalign_c = 1'b0;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          if (addr_c[1:0] == 2'b00) begin
            accept_c  = 1'b1;
            state_nxt = BUSY;
          end else begin
            misalign_c = 1'b1;
            state_nxt  = DONE;
          end
        end
      end
      BUSY: begin
        // A late ack in the expiry cycle still completes the access.
        if (bus_ack) begin
          complete_c = 1'b1;
          state_nxt  = DONE;
        end else if (tmo_expired) begin
          timeout_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kind_q    <= FETCH;
      fetch_pc  <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      instr     <= '0;
      old_pc    <= '0;
      data      <= '0;
      err       <= 1'b0;
    end else begin
      if (accept_c) begin
        kind_q    <= decode_kind(mem_write, adr_src);
        fetch_pc  <= pc;
        bus_we    <= mem_write;
        bus_addr  <= addr_c;
        bus_wdata <= wdata;
      end
      if (complete_c) begin
        case (kind_q)
          FETCH: begin
            instr  <= bus_rdata;
            old_pc <= fetch_pc;
          end
          LOAD:    data <= bus_rdata;
          default: ;
        endcase
      end
      if (misalign_c | timeout_c) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized self-checking bench for mem_port_ctrl against a transaction-level reference model.
module tb_mem_port_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            ir_write, adr_src, mem_write;
  logic [XLEN-1:0] pc, alu_out, wdata;
  logic            bus_req, bus_we;
  logic [XLEN-1:0] bus_addr, bus_wdata;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  logic [XLEN-1:0] instr, old_pc, data;
  logic            stall, err;

  int errors = 0;
  int checks = 0;

  // Architectural state expected after each completed access.
  logic [XLEN-1:0] m_instr, m_old_pc, m_data;
  logic            m_err;

  mem_port_ctrl #(
    .XLEN          (XLEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ir_write (ir_write),
    .adr_src  (adr_src),
    .mem_write(mem_write),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .instr    (instr),
    .old_pc   (old_pc),
    .data     (data),
    .stall    (stall),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    ir_write  = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic model_reset();
    m_instr  = '0;
    m_old_pc = '0;
    m_data   = '0;
    m_err    = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, "_instr"}, instr, m_instr);
    check_eq({tag, "_old_pc"}, old_pc, m_old_pc);
    check_eq({tag, "_data"}, data, m_data);
    check_eq({tag, "_err"}, XLEN'(err), XLEN'(m_err));
  endtask

  // Leaves the bench at a falling edge with the DUT idle.
  task automatic do_reset();
    clear_req();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // kind: 0 fetch, 1 load, 2 store. lat: BUSY cycle on which ack arrives (beyond TMO = never).
  task automatic run_txn(input string tag, input int kind, input logic [XLEN-1:0] pcv,
                         input logic [XLEN-1:0] aluv, input logic [XLEN-1:0] wdv,
                         input logic [XLEN-1:0] rdv, input int lat, input bit drop);
    logic [XLEN-1:0] addr;
    bit mis, stall_done, finished;
    int n_busy, n_stall, eff;
    addr       = (kind == 0) ? pcv : aluv;
    mis        = (addr[1:0] != 2'b00);
    eff        = (lat <= int'(TMO)) ? lat : int'(TMO);
    n_busy     = 0;
    n_stall    = 0;
    stall_done = 1'b0;
    finished   = 1'b0;
    pc        = pcv;
    alu_out   = aluv;
    wdata     = wdv;
    ir_write  = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    adr_src   = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_write = (kind == 2);
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (!stall_done) begin
        if (stall) n_stall++;
        else       stall_done = 1'b1;
      end
      if (bus_req) begin
        n_busy++;
        check_eq({tag, "_addr"}, bus_addr, addr);
        check_eq({tag, "_we"}, XLEN'(bus_we), XLEN'(kind == 2));
        if (kind == 2) check_eq({tag, "_wdata"}, bus_wdata, wdv);
        bus_rdata = (n_busy == lat) ? rdv : XLEN'($urandom);
        bus_ack   = (n_busy == lat);
        if (drop) clear_req();
      end else begin
        bus_ack = 1'b0;
        if (stall_done) begin
          finished = 1'b1;
          break;
        end
      end
      @(negedge clock);
    end
    check_eq({tag, "_finished"}, XLEN'(finished), XLEN'(1));
    bus_ack = 1'b0;
    clear_req();
    check_eq({tag, "_busy_cycles"}, XLEN'(n_busy), XLEN'(mis ? 0 : eff));
    if (!drop) check_eq({tag, "_stall_cycles"}, XLEN'(n_stall), XLEN'(mis ? 1 : 1 + eff));
    if (mis || lat > int'(TMO)) begin
      m_err = 1'b1;
    end else if (kind == 0) begin
      m_instr  = rdv;
      m_old_pc = pcv;
    end else if (kind == 1) begin
      m_data = rdv;
    end
    @(negedge clock);
    #1;
    check_arch(tag);
    check_eq({tag, "_idle_req"}, XLEN'(bus_req), XLEN'(0));
  endtask

  // Idle gap with stray acks that must be ignored; returns at a falling edge.
  task automatic idle_gap(input int n);
    for (int g = 0; g <= n; g++) begin
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = XLEN'($urandom);
      @(negedge clock);
    end
    bus_ack = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rand_addr();
    logic [XLEN-1:0] a;
    a = XLEN'($urandom) & ~XLEN'(3);
    if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    clear_req();
    pc        = '0;
    alu_out   = '0;
    wdata     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    do_reset();
    #1;
    check_arch("reset");
    check_eq("reset_bus_req", XLEN'(bus_req), XLEN'(0));
    check_eq("reset_bus_addr", bus_addr, '0);
    check_eq("reset_stall", XLEN'(stall), XLEN'(0));
    @(negedge clock);

    run_txn("fetch", 0, 32'h100, 32'h0, 32'h0, 32'h0050_0093, 1, 1'b0);
    idle_gap(1);
    run_txn("load_wait", 1, 32'h200, 32'h2004, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    idle_gap(0);
    run_txn("store", 2, 32'h204, 32'h2008, 32'h1234_5678, 32'hFFFF_FFFF, 2, 1'b0);
    idle_gap(0);
    run_txn("misaligned", 1, 32'h208, 32'h2002, 32'h0, 32'h0, 1, 1'b0);
    idle_gap(0);
    run_txn("err_sticky", 0, 32'h20C, 32'h0, 32'h0, 32'hCAFE_0001, 1, 1'b0);
    do_reset();
    run_txn("timeout", 1, 32'h300, 32'h4000, 32'h0, 32'h0, 99, 1'b0);
    idle_gap(0);
    run_txn("req_drop", 0, 32'h304, 32'h0, 32'h0, 32'hA5A5_0002, 3, 1'b1);

    // Reset in the second BUSY cycle abandons the access.
    do_reset();
    alu_out = 32'h3000;
    adr_src = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_busy_pre_req", XLEN'(bus_req), XLEN'(1));
    reset = 1'b1;
    #1;
    check_eq("rst_busy_req", XLEN'(bus_req), XLEN'(0));
    check_eq("rst_busy_addr", bus_addr, '0);
    check_arch("rst_busy");
    clear_req();
    model_reset();
    @(negedge clock);
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    check_arch("rst_late_ack");
    check_eq("rst_late_req", XLEN'(bus_req), XLEN'(0));
    @(negedge clock);

    for (int t = 0; t < 60; t++) begin
      int kind, lat;
      if (t % 10 == 0) do_reset();
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(1, int'(TMO) + 2);
      run_txn("rand", kind, rand_addr(), rand_addr(), XLEN'($urandom), XLEN'($urandom), lat,
              ($urandom_range(0, 5) == 0));
      idle_gap($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
